baccarat_round_sequencer: RTL and testbench

Round-level controller for the baccarat datapath. It requests cards from the card source with a ready/valid handshake and steers each accepted card to the correct hand-register load strobe in deal order. It keeps running player and dealer scores, applies the natural and third-card rules, and drives the win lights. It also keeps saturating win/tie tallies across rounds. It sits between the card source and the existing card registers and score displays, and replaces ad-hoc per-state load sequencing.

---
 rtl/baccarat_pkg.sv | 49 ++++
 rtl/baccarat_round_sequencer_hand_accum.sv | 48 ++++
 rtl/baccarat_round_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_baccarat_round_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types, constants and card/rule helpers for the baccarat round sequencer.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_P1     = 4'd1,
    S_D1     = 4'd2,
    S_P2     = 4'd3,
    S_D2     = 4'd4,
    S_DECIDE = 4'd5,
    S_P3     = 4'd6,
    S_D3     = 4'd7,
    S_RESULT = 4'd8
  } state_e;

  // A two-card total at or above this ends the round immediately.
  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  // Highest total at which a hand takes a third card.
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

  // Rank 1..9 counts face value, 10..13 count zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    if (rank >= 4'd1 && rank <= 4'd9) begin
      card_value = rank;
    end else begin
      card_value = 4'd0;
    end
  endfunction

  // Only A..K are legal ranks; anything else is left on the bus unconsumed.
  function automatic logic rank_ok(input logic [3:0] rank);
    rank_ok = (rank >= 4'd1) && (rank <= 4'd13);
  endfunction

  // Dealer third-card rule, keyed on the dealer two-card total and the
  // value of the player's third card.
  function automatic logic dealer_draws(input logic [3:0] dscore,
                                        input logic [3:0] p3_val);
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (p3_val != 4'd8);
      4'd4:             dealer_draws = (p3_val >= 4'd2) && (p3_val <= 4'd7);
      4'd5:             dealer_draws = (p3_val >= 4'd4) && (p3_val <= 4'd7);
      4'd6:             dealer_draws = (p3_val >= 4'd6) && (p3_val <= 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/baccarat_round_sequencer_hand_accum.sv
// Mod-10 hand score accumulator: clear has priority over add.
import baccarat_pkg::*;

module hand_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add,
  input  logic [3:0] rank,
  output logic [3:0] score,
  output logic [3:0] score_nxt
);

  logic [3:0] score_q;
  logic [3:0] score_d;
  logic [3:0] val;
  logic [3:0] gap;

  // Next score; (score + val) mod 10 done in 4 bits by comparing against
  // the distance to ten instead of forming a 5-bit sum.
  always_comb begin
    val     = card_value(rank);
    gap     = 4'd10 - val;
    score_d = score_q;
    if (clear) begin
      score_d = 4'd0;
    end else if (add) begin
      if (score_q >= gap) begin
        score_d = score_q - gap;
      end else begin
        score_d = score_q + val;
      end
    end
  end

  // Score register, falling-edge clocked like the rest of the datapath.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      score_q <= 4'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score     = score_q;
  assign score_nxt = score_d;

endmodule

// File: rtl/baccarat_round_sequencer.sv
// Round controller: requests cards, steers load strobes, applies the
// natural / third-card rules, drives win lights and keeps win tallies.
//
// Handshake: a card is taken on a falling edge where card_req and
// card_valid are both high and card holds a legal rank (1..13). Illegal
// ranks are never consumed and card_req stays high; card_req depends only
// on state, so it never waits on card_valid.
import baccarat_pkg::*;

module baccarat_round_sequencer #(
  parameter int TALLY_W = 4
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic               start,
  input  logic               card_valid,
  input  logic [3:0]         card,
  output logic               card_req,
  output logic [3:0]         card_out,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic [3:0]         pscore,
  output logic [3:0]         dscore,
  output logic [3:0]         pcard3_val,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               done,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties,
  output logic [3:0]         state_dbg
);

  localparam logic [TALLY_W-1:0] TALLY_ONE = TALLY_W'(1);
  localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

  state_e             state_q, state_d;
  logic [5:0]         load_q, load_d;      // bit k = deal slot k (p1,d1,p2,d2,p3,d3)
  logic [3:0]         card_out_q, card_out_d;
  logic [3:0]         pcard3_q, pcard3_d;
  logic               plight_q, plight_d;
  logic               dlight_q, dlight_d;
  logic [TALLY_W-1:0] pw_q, pw_d;
  logic [TALLY_W-1:0] dw_q, dw_d;
  logic [TALLY_W-1:0] tie_q, tie_d;

  logic       accept;
  logic       new_round;
  logic       enter_result;
  logic       p_add;
  logic       d_add;
  logic [3:0] pscore_q, dscore_q;
  logic [3:0] pscore_nxt, dscore_nxt;

  hand_accum u_player (
    .clk       (slow_clock),
    .rst       (reset),
    .clear     (new_round),
    .add       (p_add),
    .rank      (card),
    .score     (pscore_q),
    .score_nxt (pscore_nxt)
  );

  hand_accum u_dealer (
    .clk       (slow_clock),
    .rst       (reset),
    .clear     (new_round),
    .add       (d_add),
    .rank      (card),
    .score     (dscore_q),
    .score_nxt (dscore_nxt)
  );

  // Next state, handshake, strobe steering and accumulator enables.
  always_comb begin
    state_d   = state_q;
    card_req  = 1'b0;
    load_d    = 6'b000000;
    p_add     = 1'b0;
    d_add     = 1'b0;
    new_round = 1'b0;

    case (state_q)
      S_P1, S_D1, S_P2, S_D2, S_P3, S_D3: card_req = 1'b1;
      default:                            card_req = 1'b0;
    endcase

    accept = card_req && card_valid && rank_ok(card);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_P1;
          new_round = 1'b1;
        end
      end
      S_P1: begin
        if (accept) begin
          state_d   = S_D1;
          load_d[0] = 1'b1;
          p_add     = 1'b1;
        end
      end
      S_D1: begin
        if (accept) begin
          state_d   = S_P2;
          load_d[1] = 1'b1;
          d_add     = 1'b1;
        end
      end
      S_P2: begin
        if (accept) begin
          state_d   = S_D2;
          load_d[2] = 1'b1;
          p_add     = 1'b1;
        end
      end
      S_D2: begin
        if (accept) begin
          state_d   = S_DECIDE;
          load_d[3] = 1'b1;
          d_add     = 1'b1;
        end
      end
      S_DECIDE: begin
        if (pscore_q >= NATURAL_MIN || dscore_q >= NATURAL_MIN) begin
          state_d = S_RESULT;
        end else if (pscore_q <= PLAYER_DRAW_MAX) begin
          state_d = S_P3;
        end else if (dscore_q <= PLAYER_DRAW_MAX) begin
          state_d = S_D3;
        end else begin
          state_d = S_RESULT;
        end
      end
      S_P3: begin
        if (accept) begin
          load_d[4] = 1'b1;
          p_add     = 1'b1;
          // Dealer rule looks at the card being taken now, not the old register.
          state_d   = dealer_draws(dscore_q, card_value(card)) ? S_D3 : S_RESULT;
        end
      end
      S_D3: begin
        if (accept) begin
          state_d   = S_RESULT;
          load_d[5] = 1'b1;
          d_add     = 1'b1;
        end
      end
      S_RESULT: begin
        if (start) begin
          state_d   = S_P1;
          new_round = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    enter_result = (state_d == S_RESULT) && (state_q != S_RESULT);
  end

  // Card copy, third-card value, lights and tallies.
  always_comb begin
    card_out_d = card_out_q;
    pcard3_d   = pcard3_q;
    plight_d   = plight_q;
    dlight_d   = dlight_q;
    pw_d       = pw_q;
    dw_d       = dw_q;
    tie_d      = tie_q;

    if (accept) begin
      card_out_d = card;
    end

    if (new_round) begin
      pcard3_d = 4'd0;
    end else if (accept && state_q == S_P3) begin
      pcard3_d = card_value(card);
    end

    if (new_round) begin
      plight_d = 1'b0;
      dlight_d = 1'b0;
    end else if (enter_result) begin
      // Use the post-edge scores so a final third card is counted.
      plight_d = (pscore_nxt >= dscore_nxt);
      dlight_d = (dscore_nxt >= pscore_nxt);
      if (pscore_nxt == dscore_nxt) begin
        if (tie_q != TALLY_MAX) tie_d = tie_q + TALLY_ONE;
      end else if (pscore_nxt > dscore_nxt) begin
        if (pw_q != TALLY_MAX) pw_d = pw_q + TALLY_ONE;
      end else begin
        if (dw_q != TALLY_MAX) dw_d = dw_q + TALLY_ONE;
      end
    end
  end

  // All sequencer registers; reset clears everything including tallies.
  always_ff @(negedge slow_clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_q     <= 6'b000000;
      card_out_q <= 4'd0;
      pcard3_q   <= 4'd0;
      plight_q   <= 1'b0;
      dlight_q   <= 1'b0;
      pw_q       <= '0;
      dw_q       <= '0;
      tie_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      card_out_q <= card_out_d;
      pcard3_q   <= pcard3_d;
      plight_q   <= plight_d;
      dlight_q   <= dlight_d;
      pw_q       <= pw_d;
      dw_q       <= dw_d;
      tie_q      <= tie_d;
    end
  end

  assign card_out         = card_out_q;
  assign load_pcard1      = load_q[0];
  assign load_dcard1      = load_q[1];
  assign load_pcard2      = load_q[2];
  assign load_dcard2      = load_q[3];
  assign load_pcard3      = load_q[4];
  assign load_dcard3      = load_q[5];
  assign pscore           = pscore_q;
  assign dscore           = dscore_q;
  assign pcard3_val       = pcard3_q;
  assign player_win_light = plight_q;
  assign dealer_win_light = dlight_q;
  assign done             = (state_q == S_RESULT);
  assign player_wins      = pw_q;
  assign dealer_wins      = dw_q;
  assign ties             = tie_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_baccarat_round_sequencer.sv
// Bench for baccarat_round_sequencer: table rounds, corner sequences and
// random decks checked against a rule-level round model.
import baccarat_pkg::*;

module tb_baccarat_round_sequencer;

  localparam int TW   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic          slow_clock, reset, start, card_valid;
  logic [3:0]    card;
  logic          card_req;
  logic [3:0]    card_out;
  logic          load_pcard1, load_pcard2, load_pcard3;
  logic          load_dcard1, load_dcard2, load_dcard3;
  logic [3:0]    pscore, dscore, pcard3_val;
  logic          player_win_light, dealer_win_light, done;
  logic [TW-1:0] player_wins, dealer_wins, ties;
  logic [3:0]    state_dbg;

  baccarat_round_sequencer #(.TALLY_W(TW)) dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .start            (start),
    .card_valid       (card_valid),
    .card             (card),
    .card_req         (card_req),
    .card_out         (card_out),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3_val       (pcard3_val),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .done             (done),
    .player_wins      (player_wins),
    .dealer_wins      (dealer_wins),
    .ties             (ties),
    .state_dbg        (state_dbg)
  );

  // Clock and reset
  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  typedef struct {
    logic [5:0][3:0] c;   // deck in arrival order
    int              n;   // cards the round consumes
    logic [3:0]      ps, ds, p3;
    logic            hp, hd;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int e_pw = 0, e_dw = 0, e_t = 0;
  vec_t tbl[7];

  // Scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
  endfunction

  function automatic vec_t mk(int n, int c0, int c1, int c2, int c3, int c4, int c5,
                              int ps, int ds, int p3, int hp, int hd);
    vec_t v;
    v.c[0] = 4'(c0); v.c[1] = 4'(c1); v.c[2] = 4'(c2);
    v.c[3] = 4'(c3); v.c[4] = 4'(c4); v.c[5] = 4'(c5);
    v.n  = n;
    v.ps = 4'(ps); v.ds = 4'(ds); v.p3 = 4'(p3);
    v.hp = hp[0];  v.hd = hd[0];
    return v;
  endfunction

  // Reference model: play the round from the deck with the baccarat rules.
  function automatic int pts(input logic [3:0] r);
    return (int'(r) < 10) ? int'(r) : 0;
  endfunction

  function automatic vec_t model(input logic [5:0][3:0] d);
    // draw_mask[t] bit k: dealer with two-card total t draws on player third value k
    int draw_mask[10];
    int ps, ds, p3v;
    vec_t v;
    draw_mask = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC, 10'h0F0, 10'h0C0, 0, 0, 0};
    v.c = d; v.hp = 1'b0; v.hd = 1'b0; v.n = 4; p3v = 0;
    ps = (pts(d[0]) + pts(d[2])) % 10;
    ds = (pts(d[1]) + pts(d[3])) % 10;
    if (ps < 8 && ds < 8) begin
      if (ps <= 5) begin
        p3v = pts(d[4]); v.hp = 1'b1; v.n = 5;
        ps = (ps + p3v) % 10;
        if (draw_mask[ds][p3v]) begin
          v.hd = 1'b1; v.n = 6;
          ds = (ds + pts(d[5])) % 10;
        end
      end else if (ds <= 5) begin
        v.hd = 1'b1; v.n = 5;
        ds = (ds + pts(d[4])) % 10;
      end
    end
    v.ps = 4'(ps); v.ds = 4'(ds); v.p3 = 4'(p3v);
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_card_req"}, card_req, 0);
    chk({tag, "_card_out"}, card_out, 0);
    chk({tag, "_strobes"}, strobes(), 0);
    chk({tag, "_scores"}, {pscore, dscore, pcard3_val}, 0);
    chk({tag, "_lights_done"}, {player_win_light, dealer_win_light, done}, 0);
    chk({tag, "_tallies"}, {player_wins, dealer_wins, ties}, 0);
    chk({tag, "_state"}, state_dbg, S_IDLE);
  endtask

  // Driver: start a round, feed the deck, check strobes and results.
  // mode 0: clean feed; 1: random stalls and bad ranks; 2: scripted stall + rank 14.
  task automatic run_round(input vec_t v, input int mode);
    logic [3:0] deck[$];
    int         ord[$];
    int         cyc, k, r, b;
    logic       acc, pl, dl;
    logic [3:0] last, st;
    last = 4'd0;
    for (int i = 0; i < v.n; i++) deck.push_back(v.c[i]);
    ord = '{0, 1, 2, 3};
    if (v.hp) ord.push_back(4);
    if (v.hd) ord.push_back(5);

    start = 1'b1; card_valid = 1'b0; card = 4'd0;
    @(negedge slow_clock); #1;
    start = 1'b0;
    chk("start_req", card_req, 1);
    chk("start_clear", {pscore, dscore, pcard3_val, player_win_light, dealer_win_light, done}, 0);

    if (mode == 2) begin
      st = state_dbg;
      for (int i = 0; i < 5; i++) begin
        card_valid = 1'b0; card = 4'($urandom_range(1, 13));
        @(negedge slow_clock); #1;
        chk("stall_strobe", strobes(), 0);
        chk("stall_state", state_dbg, st);
        chk("stall_req", card_req, 1);
      end
      for (int i = 0; i < 2; i++) begin
        card_valid = 1'b1; card = 4'd14;
        @(negedge slow_clock); #1;
        chk("badrank_strobe", strobes(), 0);
        chk("badrank_req", card_req, 1);
        chk("badrank_score", pscore, 0);
      end
    end

    cyc = 0; k = 0;
    while (!done && cyc < 100) begin
      r = (mode == 1) ? $urandom_range(0, 5) : 5;
      if (r == 0) begin
        card_valid = 1'b0; card = 4'($urandom_range(1, 13));
      end else if (r == 1) begin
        b = $urandom_range(0, 2);
        card_valid = 1'b1; card = (b == 0) ? 4'd0 : ((b == 1) ? 4'd14 : 4'd15);
      end else begin
        card_valid = (deck.size() > 0);
        card = (deck.size() > 0) ? deck[0] : 4'd0;
      end
      acc = card_req && card_valid && (card >= 4'd1) && (card <= 4'd13);
      @(negedge slow_clock); #1;
      if (acc && k < ord.size()) begin
        last = deck.pop_front();
        chk("strobe", strobes(), 6'b1 << ord[k]);
        k++;
      end else begin
        chk("no_strobe", strobes(), 0);
      end
      cyc++;
    end
    card_valid = 1'b0;
    chk("round_done", done, 1);
    chk("cards_used", k, ord.size());
    chk("card_out", card_out, last);
    chk("pscore", pscore, v.ps);
    chk("dscore", dscore, v.ds);
    chk("pcard3_val", pcard3_val, v.p3);
    pl = (v.ps >= v.ds);
    dl = (v.ds >= v.ps);
    chk("lights", {player_win_light, dealer_win_light}, {pl, dl});
    if (pl && dl) begin
      if (e_t < TMAX) e_t++;
    end else if (pl) begin
      if (e_pw < TMAX) e_pw++;
    end else begin
      if (e_dw < TMAX) e_dw++;
    end
    chk("player_wins", player_wins, e_pw);
    chk("dealer_wins", dealer_wins, e_dw);
    chk("ties", ties, e_t);
  endtask

  initial begin
    vec_t rv;
    logic [5:0][3:0] d;

    //            n  c0 c1 c2 c3 c4 c5  ps ds p3 hp hd
    tbl[0] = mk(4, 4, 3, 5, 3, 0, 0,   9, 6, 0, 0, 0);  // player natural
    tbl[1] = mk(6, 2, 10, 3, 13, 4, 7, 9, 7, 4, 1, 1);  // both draw
    tbl[2] = mk(5, 7, 2, 11, 3, 3, 0,  7, 8, 0, 0, 1);  // player stands, dealer draws
    tbl[3] = mk(5, 1, 1, 2, 2, 8, 0,   1, 3, 8, 1, 0);  // dealer stands via table
    tbl[4] = mk(4, 3, 4, 4, 3, 0, 0,   7, 7, 0, 0, 0);  // tie, both stand
    tbl[5] = mk(4, 1, 9, 2, 13, 0, 0,  3, 9, 0, 0, 0);  // dealer natural
    tbl[6] = mk(6, 10, 10, 10, 10, 5, 6, 5, 6, 5, 1, 1); // all-zero first four

    reset = 1'b1; start = 1'b0; card_valid = 1'b0; card = 4'd0;
    #12;
    check_all_zero("reset");
    @(posedge slow_clock);
    reset = 1'b0;
    @(negedge slow_clock); #1;
    chk("idle_req", card_req, 0);

    run_round(tbl[0], 0);

    // Reset mid-round in D2: everything clears without waiting for an edge.
    start = 1'b1;
    @(negedge slow_clock); #1;
    start = 1'b0; card_valid = 1'b1; card = 4'd2;
    @(negedge slow_clock); #1; card = 4'd3;
    @(negedge slow_clock); #1; card = 4'd4;
    @(negedge slow_clock); #1; card_valid = 1'b0;
    chk("in_d2_state", state_dbg, S_D2);
    chk("in_d2_req", card_req, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge slow_clock);
    reset = 1'b0;
    @(negedge slow_clock); #1;
    chk("post_reset_state", state_dbg, S_IDLE);
    e_pw = 0; e_dw = 0; e_t = 0;

    for (int i = 0; i < 7; i++) run_round(tbl[i], 0);
    run_round(tbl[4], 2);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 6; i++) d[i] = 4'($urandom_range(1, 13));
      rv = model(d);
      run_round(rv, 1);
    end

    for (int i = 0; i < 16; i++) run_round(tbl[0], 0);
    chk("player_wins_sat", player_wins, TMAX);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
